// File: rtl/sync_ram_if.sv
// Request/response bundle for sync_ram.
//   req_valid/req_ready : request handshake; a request is taken when both are 1
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata  : word address and write data
//   rsp_valid           : one-cycle pulse per accepted read
//   rsp_rdata/rsp_err   : read data and out-of-range flag, valid with rsp_valid
interface sync_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with valid/ready requests and registered read
// data (1-cycle latency). Optionally clears every word to CLEAR_VAL after reset.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : sync_ram_if slave modport (request + response)
//   init_busy : clear sequence in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | clearing mem[cnt] each cycle; requests not accepted
// ST_RUN  | accepting one request per cycle until the next reset
module sync_ram #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 4,
  parameter int                DEPTH          = 16,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_ram_if.slave   bus,
  output logic        init_busy
);

  localparam int                CNT_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic              CLR_EN    = (CLEAR_ON_RESET != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic in_range;
  logic accept;
  logic rd_acc;
  logic wr_acc;

  // Zero-extended compare so DEPTH == 2**ADDR_W needs no special case.
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
  assign accept   = bus.req_valid & ready_q;
  assign rd_acc   = accept & ~bus.req_we;
  assign wr_acc   = accept & bus.req_we & in_range;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;

    if (state_q == ST_INIT) begin
      // Counter holds at the last word; leaving INIT stops it.
      if (cnt_q == CNT_LAST) state_d = ST_RUN;
      else                   cnt_d   = cnt_q + 1'b1;
    end

    ready_d     = (state_d == ST_RUN);
    busy_d      = (state_d == ST_INIT);
    rsp_valid_d = rd_acc;
    rsp_err_d   = rd_acc & ~in_range;
    if (rd_acc) rsp_rdata_d = in_range ? mem[bus.req_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLR_EN ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= CLR_EN;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset. Clear and request writes are mutually exclusive
  // because req_ready is low for the whole of INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) mem[cnt_q] <= CLEAR_VAL;
    else if (wr_acc)        mem[bus.req_addr] <= bus.req_wdata;
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign init_busy     = busy_q;

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy16;
  logic busy12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_ram_if #(.DATA_W(8), .ADDR_W(4)) b16 ();
  sync_ram_if #(.DATA_W(8), .ADDR_W(4)) b12 ();

  sync_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hA5)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16), .init_busy(busy16)
  );

  sync_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(0), .CLEAR_VAL(8'h00)) u12 (
    .clk(clk), .rst_n(rst_n), .bus(b12), .init_busy(busy12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive16(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    b16.req_valid = v;
    b16.req_we    = we;
    b16.req_addr  = a;
    b16.req_wdata = d;
  endtask

  task automatic drive12(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    b12.req_valid = v;
    b12.req_we    = we;
    b12.req_addr  = a;
    b12.req_wdata = d;
  endtask

  // Counts edges until u16 raises req_ready; init_busy must stay high and
  // no response may appear until then.
  task automatic wait_ready16(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (b16.req_ready !== 1'b1 && n < 40) begin
      if (busy16 !== 1'b1 || b16.rsp_valid !== 1'b0) busy_ok = 1'b0;
      tick();
      n++;
    end
  endtask

  initial begin
    int   n;
    logic busy_ok;

    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    drive12(1'b0, 1'b0, 4'd0, 8'h00);
    rst_n = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_rsp_valid", b16.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", b16.rsp_rdata, 8'h00);
    chk("rst_rsp_err",   b16.rsp_err,   1'b0);
    chk("rst_ready16",   b16.req_ready, 1'b0);
    chk("rst_busy16",    busy16,        1'b1);
    chk("rst_ready12",   b12.req_ready, 1'b0);
    chk("rst_busy12",    busy12,        1'b0);

    // Release with a write pending during INIT; it must be ignored.
    rst_n = 1'b1;
    drive16(1'b1, 1'b1, 4'd2, 8'h77);
    tick();
    chk("run_ready12_first_edge", b12.req_ready, 1'b1);
    chk("init_busy16_first_edge", busy16, 1'b1);
    wait_ready16(n, busy_ok);
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    chk("init_len", n + 1, 16);
    chk("init_busy_held", busy_ok, 1'b1);
    chk("init_busy_done", busy16, 1'b0);

    // Cleared contents; address 2 must not hold the rejected 8'h77.
    for (int a = 0; a < 16; a++) begin
      drive16(1'b1, 1'b0, 4'(a), 8'h00);
      tick();
      chk($sformatf("clr_valid_%0d", a), b16.rsp_valid, 1'b1);
      chk($sformatf("clr_rdata_%0d", a), b16.rsp_rdata, 8'hA5);
      chk($sformatf("clr_err_%0d", a),   b16.rsp_err,   1'b0);
    end
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("clr_idle_valid", b16.rsp_valid, 1'b0);
    chk("clr_idle_hold",  b16.rsp_rdata, 8'hA5);

    // Write then read next cycle
    drive16(1'b1, 1'b1, 4'd5, 8'h3C);
    tick();
    chk("wr_no_rsp", b16.rsp_valid, 1'b0);
    drive16(1'b1, 1'b0, 4'd5, 8'h00);
    tick();
    chk("lat_valid", b16.rsp_valid, 1'b1);
    chk("lat_rdata", b16.rsp_rdata, 8'h3C);
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("lat_drop",  b16.rsp_valid, 1'b0);
    chk("lat_hold",  b16.rsp_rdata, 8'h3C);

    // Back-to-back streaming
    for (int a = 0; a < 16; a++) begin
      drive16(1'b1, 1'b1, 4'(a), 8'(a * 3));
      tick();
    end
    for (int a = 0; a < 16; a++) begin
      drive16(1'b1, 1'b0, 4'(a), 8'h00);
      tick();
      chk($sformatf("strm_valid_%0d", a), b16.rsp_valid, 1'b1);
      chk($sformatf("strm_rdata_%0d", a), b16.rsp_rdata, 32'(a * 3));
    end
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("strm_end_valid", b16.rsp_valid, 1'b0);

    // Out-of-range on the 12-word instance
    drive12(1'b1, 1'b1, 4'd11, 8'h5A);
    tick();
    drive12(1'b1, 1'b1, 4'd13, 8'hFF);
    tick();
    chk("oor_wr_no_rsp", b12.rsp_valid, 1'b0);
    drive12(1'b1, 1'b0, 4'd13, 8'h00);
    tick();
    chk("oor_valid", b12.rsp_valid, 1'b1);
    chk("oor_rdata", b12.rsp_rdata, 8'h00);
    chk("oor_err",   b12.rsp_err,   1'b1);
    drive12(1'b1, 1'b0, 4'd11, 8'h00);
    tick();
    chk("inr_valid", b12.rsp_valid, 1'b1);
    chk("inr_rdata", b12.rsp_rdata, 8'h5A);
    chk("inr_err",   b12.rsp_err,   1'b0);
    drive12(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    chk("oor_idle_valid", b12.rsp_valid, 1'b0);
    chk("oor_idle_err",   b12.rsp_err,   1'b0);
    chk("oor_idle_hold",  b12.rsp_rdata, 8'h5A);

    // Reset mid-clear at address 7
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_clr_busy", busy16, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_clr_rst_busy",  busy16,        1'b1);
    chk("mid_clr_rst_ready", b16.req_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    wait_ready16(n, busy_ok);
    chk("reclr_len", n, 16);
    chk("reclr_busy_held", busy_ok, 1'b1);
    // Address 10 held 30 before; a full restart must clear it.
    drive16(1'b1, 1'b0, 4'd10, 8'h00);
    tick();
    chk("reclr_rd10", b16.rsp_rdata, 8'hA5);
    drive16(1'b1, 1'b0, 4'd0, 8'h00);
    tick();
    chk("reclr_rd0", b16.rsp_rdata, 8'hA5);

    // Reset in the cycle after an accepted read
    drive16(1'b1, 1'b1, 4'd3, 8'h42);
    tick();
    drive16(1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    chk("pre_rst_valid", b16.rsp_valid, 1'b1);
    chk("pre_rst_rdata", b16.rsp_rdata, 8'h42);
    rst_n = 1'b0;
    #1;
    chk("async_valid", b16.rsp_valid, 1'b0);
    chk("async_rdata", b16.rsp_rdata, 8'h00);
    chk("async_busy",  busy16,        1'b1);
    tick();
    rst_n = 1'b1;
    wait_ready16(n, busy_ok);
    chk("rst2_len", n, 16);
    drive16(1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    drive16(1'b0, 1'b0, 4'd0, 8'h00);
    chk("rst2_rd3", b16.rsp_rdata, 8'hA5);
    chk("rst2_ready12", b12.req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
